// File: rtl/sed_scan_scheduler_pkg.sv
// Shared state encoding, counter widths and default timing for the SED scan scheduler.
package sed_scan_scheduler_pkg;

  localparam int SCAN_CNT_W = 16;
  localparam int ERR_CNT_W  = 8;
  localparam int CONSEC_W   = 4;

  localparam int DEF_ENABLE_DELAY = 128;
  localparam int DEF_START_LEN    = 16;
  localparam int DEF_SCAN_PERIOD  = 1000000;
  localparam int DEF_TIMEOUT      = 4000000;
  localparam int DEF_CONFIRM      = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_RUN = 3'd3,
    ST_EVAL     = 3'd4,
    ST_GAP      = 3'd5
  } sed_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sed_scan_scheduler_if.sv
// Control, SED primitive and status signals of the scan scheduler; master is the scheduler side.
interface sed_scan_scheduler_if;
  import sed_scan_scheduler_pkg::*;

  logic                  enable;
  logic                  force_scan;
  logic                  clear;
  logic                  sed_done;
  logic                  sed_inprog;
  logic                  sed_err;
  logic                  sed_enable;
  logic                  sed_start;
  logic                  busy;
  logic                  scan_done;
  logic                  fault;
  logic                  timeout;
  logic [SCAN_CNT_W-1:0] scan_count;
  logic [ERR_CNT_W-1:0]  err_count;

  modport master (
    input  enable, force_scan, clear, sed_done, sed_inprog, sed_err,
    output sed_enable, sed_start, busy, scan_done, fault, timeout, scan_count, err_count
  );

  modport slave (
    output enable, force_scan, clear, sed_done, sed_inprog, sed_err,
    input  sed_enable, sed_start, busy, scan_done, fault, timeout, scan_count, err_count
  );

endinterface

// File: rtl/sed_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sed_sat_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // count register: reset, clear, or step towards all-ones and hold there
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (clr) begin
      count <= {WIDTH{1'b0}};
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/sed_scan_scheduler.sv
// Sequences the SED primitive: enable delay, start pulse, done/error evaluation,
// scan watchdog, consecutive-error confirmation and saturating statistics.
module sed_scan_scheduler
  import sed_scan_scheduler_pkg::*;
#(
  parameter int                    ENABLE_DELAY = DEF_ENABLE_DELAY,
  parameter int                    START_LEN    = DEF_START_LEN,
  parameter int                    SCAN_PERIOD  = DEF_SCAN_PERIOD,
  parameter int                    TIMEOUT      = DEF_TIMEOUT,
  parameter int                    CONFIRM      = DEF_CONFIRM,
  parameter logic [SCAN_CNT_W-1:0] SCAN_CNT_RST = 16'h0000,
  parameter logic [ERR_CNT_W-1:0]  ERR_CNT_RST  = 8'h00
) (
  input logic                  clk,
  input logic                  rst,
  sed_scan_scheduler_if.master bus
);

  localparam int TMR_W = $clog2(max4(ENABLE_DELAY, START_LEN, SCAN_PERIOD, TIMEOUT));
  localparam logic [TMR_W-1:0]    ARM_LAST     = TMR_W'(ENABLE_DELAY - 1);
  localparam logic [TMR_W-1:0]    START_LAST   = TMR_W'(START_LEN - 1);
  localparam logic [TMR_W-1:0]    GAP_LAST     = TMR_W'(SCAN_PERIOD - 1);
  localparam logic [TMR_W-1:0]    TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CONSEC_W-1:0] CONFIRM_PRE  = CONSEC_W'(CONFIRM - 1);

  sed_state_e          state_r, state_s;
  logic [TMR_W-1:0]    timer_r, wdog_r;
  logic                done_q_r;
  logic                done_rise_s, timeout_set_s, eval_s, fault_set_s;
  logic                sed_enable_r, sed_start_r, busy_r, scan_done_r, fault_r, timeout_r;
  logic [CONSEC_W-1:0] consec_s;

  assign done_rise_s = bus.sed_done & ~done_q_r;
  assign eval_s      = (state_r == ST_EVAL);
  assign fault_set_s = eval_s & bus.sed_err & (consec_s >= CONFIRM_PRE);

  // next-state decode; dropping enable abandons any scan in flight
  always_comb begin
    state_s       = state_r;
    timeout_set_s = 1'b0;
    if (!bus.enable) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_s = ST_ARM;
        ST_ARM: begin
          if (timer_r == ARM_LAST) state_s = ST_START;
          else                     state_s = ST_ARM;
        end
        ST_START: begin
          if (timer_r == START_LAST) state_s = ST_WAIT_RUN;
          else                       state_s = ST_START;
        end
        ST_WAIT_RUN: begin
          if (done_rise_s) begin
            state_s = ST_EVAL;
          end else if (wdog_r == TIMEOUT_LAST) begin
            // via IDLE so the primitive sees one low enable cycle before the full re-arm
            state_s       = ST_IDLE;
            timeout_set_s = 1'b1;
          end else begin
            state_s = ST_WAIT_RUN;
          end
        end
        ST_EVAL:  state_s = ST_GAP;
        ST_GAP: begin
          if (bus.force_scan || (timer_r == GAP_LAST)) state_s = ST_START;
          else                                         state_s = ST_GAP;
        end
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // state, shared per-state timer, scan watchdog and done edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      timer_r  <= {TMR_W{1'b0}};
      wdog_r   <= {TMR_W{1'b0}};
      done_q_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      done_q_r <= bus.sed_done;
      if ((state_s != state_r) || (state_r == ST_IDLE)) timer_r <= {TMR_W{1'b0}};
      else                                              timer_r <= timer_r + 1'b1;
      if ((state_r == ST_START) || (state_r == ST_WAIT_RUN)) wdog_r <= wdog_r + 1'b1;
      else                                                   wdog_r <= {TMR_W{1'b0}};
    end
  end

  // outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      sed_enable_r <= 1'b0;
      sed_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      scan_done_r  <= 1'b0;
      fault_r      <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      sed_enable_r <= (state_s != ST_IDLE);
      sed_start_r  <= (state_s == ST_START);
      busy_r       <= (state_s == ST_START) || (state_s == ST_WAIT_RUN);
      scan_done_r  <= (state_s == ST_EVAL);
      if (fault_set_s)     fault_r <= 1'b1;
      else if (bus.clear)  fault_r <= 1'b0;
      else                 fault_r <= fault_r;
      if (timeout_set_s)   timeout_r <= 1'b1;
      else if (bus.clear)  timeout_r <= 1'b0;
      else                 timeout_r <= timeout_r;
    end
  end

  sed_sat_counter #(.WIDTH(SCAN_CNT_W), .RST_VAL(SCAN_CNT_RST)) u_scan_cnt (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(eval_s), .count(bus.scan_count)
  );

  sed_sat_counter #(.WIDTH(ERR_CNT_W), .RST_VAL(ERR_CNT_RST)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(eval_s & bus.sed_err), .count(bus.err_count)
  );

  sed_sat_counter #(.WIDTH(CONSEC_W), .RST_VAL(4'h0)) u_consec_cnt (
    .clk(clk), .rst(rst), .clr(bus.clear | (eval_s & ~bus.sed_err)),
    .inc(eval_s & bus.sed_err), .count(consec_s)
  );

  assign bus.sed_enable = sed_enable_r;
  assign bus.sed_start  = sed_start_r;
  assign bus.busy       = busy_r;
  assign bus.scan_done  = scan_done_r;
  assign bus.fault      = fault_r;
  assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_sed_scan_scheduler.sv
// Randomized bench for sed_scan_scheduler against an event-timing reference model.
module tb_sed_scan_scheduler;
  import sed_scan_scheduler_pkg::*;

  localparam int ED = 8, SL = 4, SP = 20, TO = 100, CF = 2;
  localparam int B_SCAN0 = 65534, B_ERR0 = 254;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0, checks = 0;

  // reference model state
  int m_scans, m_errs, m_consec, exp_start;
  bit m_fault, m_timeout;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sed_scan_scheduler_if bus_a ();
  sed_scan_scheduler_if bus_b ();

  // second instance shares stimulus but starts its counters near saturation
  assign bus_b.enable     = bus_a.enable;
  assign bus_b.force_scan = bus_a.force_scan;
  assign bus_b.clear      = bus_a.clear;
  assign bus_b.sed_done   = bus_a.sed_done;
  assign bus_b.sed_inprog = bus_a.sed_inprog;
  assign bus_b.sed_err    = bus_a.sed_err;

  sed_scan_scheduler #(.ENABLE_DELAY(ED), .START_LEN(SL), .SCAN_PERIOD(SP), .TIMEOUT(TO),
                       .CONFIRM(CF)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  sed_scan_scheduler #(.ENABLE_DELAY(ED), .START_LEN(SL), .SCAN_PERIOD(SP), .TIMEOUT(TO),
                       .CONFIRM(CF), .SCAN_CNT_RST(16'hFFFE), .ERR_CNT_RST(8'hFE))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(input int base, input int n, input int lim);
    return (base + n > lim) ? lim : base + n;
  endfunction

  task automatic check_stats(input string tag);
    check_eq({tag, ".scan"},  bus_a.scan_count, m_scans);
    check_eq({tag, ".err"},   bus_a.err_count, m_errs);
    check_eq({tag, ".fault"}, bus_a.fault, m_fault);
    check_eq({tag, ".tmo"},   bus_a.timeout, m_timeout);
    check_eq({tag, ".bscan"}, bus_b.scan_count, sat_add(B_SCAN0, m_scans, 65535));
    check_eq({tag, ".berr"},  bus_b.err_count, sat_add(B_ERR0, m_errs, 255));
  endtask

  task automatic model_eval(input bit err);
    m_scans = sat_add(m_scans, 1, 65535);
    if (err) begin
      m_errs   = sat_add(m_errs, 1, 255);
      m_consec = sat_add(m_consec, 1, 15);
      if (m_consec >= CF) m_fault = 1'b1;
    end else begin
      m_consec = 0;
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (bus_a.sed_start !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check_eq({tag, ".start_at"}, cyc, exp_start);
  endtask

  // mode 0 plain, 1 done already high entering WAIT_RUN, 2 force during WAIT_RUN
  task automatic run_scan(input string tag, input bit err, input int lat, input int mode,
                          input int force_k, input bit do_clear);
    int s, d, n;
    bit spurious;
    if (mode == 1 && lat < SL + 4) lat = SL + 4;
    wait_start(tag);
    s = cyc;
    check_eq({tag, ".busy"}, bus_a.busy, 1);
    bus_a.sed_inprog = 1'b1;
    n = 0;
    while (bus_a.sed_start === 1'b1 && n < 40) begin
      if (mode == 1 && cyc == s + 1) bus_a.sed_done = 1'b1;
      step();
      n++;
    end
    check_eq({tag, ".start_len"}, n, SL);
    d = s + lat;
    spurious = 1'b0;
    while (cyc < d) begin
      if (mode == 1 && cyc == s + SL + 2) bus_a.sed_done = 1'b0;
      bus_a.force_scan = (mode == 2 && cyc == s + SL + 1);
      spurious |= bus_a.scan_done;
      step();
    end
    bus_a.force_scan = 1'b0;
    spurious |= bus_a.scan_done;
    bus_a.sed_err    = err;
    bus_a.sed_done   = 1'b1;
    bus_a.sed_inprog = 1'b0;
    step();
    check_eq({tag, ".early_done"}, spurious, 0);
    check_eq({tag, ".done_pulse"}, bus_a.scan_done, 1);
    model_eval(err);
    step();
    bus_a.sed_done = 1'b0;
    bus_a.sed_err  = 1'b0;
    check_eq({tag, ".done_len"}, bus_a.scan_done, 0);
    check_stats(tag);
    if (do_clear) begin
      bus_a.clear = 1'b1;
      step();
      bus_a.clear = 1'b0;
      m_fault = 1'b0; m_timeout = 1'b0; m_consec = 0;
      check_stats({tag, ".clr"});
    end
    if (force_k >= 0) begin
      while (cyc < d + 2 + force_k) step();
      bus_a.force_scan = 1'b1;
      exp_start = cyc + 1;
      step();
      bus_a.force_scan = 1'b0;
    end else begin
      exp_start = d + 2 + SP;
    end
  endtask

  initial begin
    int s, c1;
    bit spurious;
    bus_a.enable = 1'b0; bus_a.force_scan = 1'b0; bus_a.clear = 1'b0;
    bus_a.sed_done = 1'b0; bus_a.sed_inprog = 1'b0; bus_a.sed_err = 1'b0;
    m_scans = 0; m_errs = 0; m_consec = 0; m_fault = 1'b0; m_timeout = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_eq("rst.sed_enable", bus_a.sed_enable, 0);
    check_eq("rst.sed_start", bus_a.sed_start, 0);
    check_eq("rst.busy", bus_a.busy, 0);
    check_eq("rst.scan_done", bus_a.scan_done, 0);
    check_stats("rst");
    rst = 1'b0;
    step();
    bus_a.enable = 1'b1;
    exp_start = cyc + 1 + ED;
    step();
    check_eq("arm.sed_enable", bus_a.sed_enable, 1);

    for (int i = 0; i < 3; i++) run_scan("clean", 1'b0, SL + $urandom_range(0, 40), 0, -1, 1'b0);
    check_eq("clean.count3", bus_a.scan_count, 3);
    run_scan("pat1", 1'b1, SL + 5, 0, -1, 1'b0);
    run_scan("pat0", 1'b0, SL + 6, 0, -1, 1'b0);
    run_scan("pat1b", 1'b1, SL, 0, -1, 1'b0);
    run_scan("pat1c", 1'b1, SL + 7, 0, -1, 1'b1);
    run_scan("force3", 1'b0, SL + 9, 0, 3, 1'b0);
    run_scan("force_wr", 1'b0, SL + 10, 2, -1, 1'b0);
    run_scan("pre_high", 1'b1, SL + 8, 1, -1, 1'b0);

    wait_start("drop");
    s = cyc;
    while (cyc < s + SL + 2) step();
    bus_a.enable = 1'b0;
    step();
    check_eq("drop.sed_enable", bus_a.sed_enable, 0);
    check_eq("drop.busy", bus_a.busy, 0);
    bus_a.sed_done = 1'b1;
    bus_a.sed_err  = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      spurious |= bus_a.scan_done;
    end
    check_eq("drop.no_eval", spurious, 0);
    check_stats("drop");
    bus_a.sed_done = 1'b0;
    bus_a.sed_err  = 1'b0;
    step();
    c1 = cyc;
    bus_a.enable = 1'b1;
    exp_start = c1 + 1 + ED;
    step();
    check_eq("reen.sed_enable", bus_a.sed_enable, 1);

    wait_start("tmo");
    s = cyc;
    while (cyc < s + TO - 1) step();
    check_eq("tmo.before", bus_a.timeout, 0);
    step();
    m_timeout = 1'b1;
    check_eq("tmo.flag", bus_a.timeout, 1);
    check_eq("tmo.en_low", bus_a.sed_enable, 0);
    step();
    check_eq("tmo.en_back", bus_a.sed_enable, 1);
    exp_start = s + TO + 1 + ED;
    run_scan("post_tmo", 1'b0, SL + 3, 0, -1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      run_scan("rnd", 1'($urandom_range(0, 1)), SL + 4 + $urandom_range(0, 50),
               $urandom_range(0, 2), ($urandom_range(0, 2) == 0) ? $urandom_range(1, SP - 2) : -1,
               ($urandom_range(0, 3) == 0));
    end

    wait_start("mid_rst");
    step();
    rst = 1'b1;
    step();
    m_scans = 0; m_errs = 0; m_consec = 0; m_fault = 1'b0; m_timeout = 1'b0;
    check_eq("mid_rst.sed_start", bus_a.sed_start, 0);
    check_eq("mid_rst.sed_enable", bus_a.sed_enable, 0);
    check_stats("mid_rst");
    rst = 1'b0;
    bus_a.enable = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
